// File: rtl/obi_cut_fifo.sv
// OBI register slice with circular-buffer FIFOs on the A and R channels.
// Credit gating limits outstanding transactions to the R FIFO depth.

module obi_cut_fifo_buf #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CW-1:0] DepthC = CW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DepthC);
    assign data_o  = mem_q[rptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        if (pop_ok)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is data-only; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end
endmodule

// Flattened OBI ports: req = {rready, a, req}, rsp = {r, rvalid, gnt}.
module obi_cut_fifo #(
    parameter bit          UseRReady = 1'b0,
    parameter int unsigned AChanW    = 32,
    parameter int unsigned RChanW    = 32,
    parameter int unsigned ReqDepth  = 2,
    parameter int unsigned RspDepth  = 2,
    parameter int unsigned CntW      = $clog2(RspDepth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AChanW+1:0] sbr_port_req_i,
    output logic [RChanW+1:0] sbr_port_rsp_o,
    output logic [AChanW+1:0] mgr_port_req_o,
    input  logic [RChanW+1:0] mgr_port_rsp_i,
    output logic [CntW-1:0]   outstanding_o,
    output logic              idle_o
);
    localparam logic [CntW-1:0] MaxCnt = CntW'(RspDepth);

    logic              sbr_req, sbr_rready, sbr_gnt;
    logic              mgr_gnt, mgr_rvalid, mgr_req, mgr_rready;
    logic [AChanW-1:0] sbr_a, a_head;
    logic [RChanW-1:0] mgr_r, r_head;
    logic              a_empty, a_full, r_empty, r_full;
    logic              a_push, a_pop, r_push, r_pop;
    logic [CntW-1:0]   credit;
    logic [CntW-1:0]   cnt_q, cnt_d;

    assign sbr_req    = sbr_port_req_i[0];
    assign sbr_a      = sbr_port_req_i[AChanW:1];
    assign sbr_rready = sbr_port_req_i[AChanW+1] || !UseRReady;
    assign mgr_gnt    = mgr_port_rsp_i[0];
    assign mgr_rvalid = mgr_port_rsp_i[1];
    assign mgr_r      = mgr_port_rsp_i[RChanW+1:2];

    assign sbr_gnt = !a_full && !rst_i;
    assign a_push  = sbr_req && sbr_gnt;

    // Credit only shrinks on a downstream grant, so a raised req holds until granted.
    assign credit  = MaxCnt - cnt_q;
    assign mgr_req = !a_empty && (credit != '0);
    assign a_pop   = mgr_req && mgr_gnt;

    assign mgr_rready = UseRReady && !r_full && !rst_i;
    assign r_push     = mgr_rvalid && (mgr_rready || !UseRReady);
    assign r_pop      = !r_empty && sbr_rready;

    always_comb begin
        cnt_d = cnt_q;
        if (a_pop && !r_pop && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (r_pop && !a_pop && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    obi_cut_fifo_buf #(.Depth(ReqDepth), .Width(AChanW)) i_a_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (a_push),
        .data_i  (sbr_a),
        .pop_i   (a_pop),
        .data_o  (a_head),
        .empty_o (a_empty),
        .full_o  (a_full)
    );

    obi_cut_fifo_buf #(.Depth(RspDepth), .Width(RChanW)) i_r_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (r_push),
        .data_i  (mgr_r),
        .pop_i   (r_pop),
        .data_o  (r_head),
        .empty_o (r_empty),
        .full_o  (r_full)
    );

    assign sbr_port_rsp_o = {r_head, !r_empty, sbr_gnt};
    assign mgr_port_req_o = {mgr_rready, a_head, mgr_req};
    assign outstanding_o  = cnt_q;
    assign idle_o         = a_empty && r_empty && (cnt_q == '0);
endmodule

// File: tb/tb_obi_cut_fifo.sv
// Bench for obi_cut_fifo: instance 0 is depth 2/2 with rready, instance 1 is depth 1/1 without.
// Handshake rule: a beat transfers at a rising edge when valid/req and ready/gnt are both high.

module tb_obi_cut_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic [33:0] s_req [2];
  logic [33:0] s_rsp [2];
  logic [33:0] m_req [2];
  logic [33:0] m_rsp [2];
  logic [1:0]  outst0;
  logic [0:0]  outst1;
  logic        idle [2];

  logic [31:0] iss_mem [2][2048];
  int          iss_wr [2];
  logic        up_rready [2];
  logic        hold_gnt [2];
  logic        rand_en [2];

  int checks = 0;
  int failures = 0;

  obi_cut_fifo #(.UseRReady(1'b1), .AChanW(32), .RChanW(32), .ReqDepth(2), .RspDepth(2)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .sbr_port_req_i(s_req[0]), .sbr_port_rsp_o(s_rsp[0]),
    .mgr_port_req_o(m_req[0]), .mgr_port_rsp_i(m_rsp[0]), .outstanding_o(outst0), .idle_o(idle[0])
  );

  obi_cut_fifo #(.UseRReady(1'b0), .AChanW(32), .RChanW(32), .ReqDepth(1), .RspDepth(1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .sbr_port_req_i(s_req[1]), .sbr_port_rsp_o(s_rsp[1]),
    .mgr_port_req_o(m_req[1]), .mgr_port_rsp_i(m_rsp[1]), .outstanding_o(outst1), .idle_o(idle[1])
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-port upstream driver, downstream subordinate model and R scoreboard.
  for (genvar k = 0; k < 2; k++) begin : g_port
    localparam bit NoRReady = (k == 1);
    logic [31:0] exp_q [$];
    logic [31:0] pend_q [$];
    int          dly_q [$];
    int          gwait = 0;
    int          iss_rd = 0;
    int          grants = 0;
    int          rcv = 0;
    logic        gnt_v;

    initial begin
      s_req[k] = '0;
      m_rsp[k] = '0;
      forever begin
        @(posedge clk);
        #1;
        s_req[k] = {up_rready[k], iss_mem[k][iss_rd], iss_rd != iss_wr[k]};
        gnt_v = !hold_gnt[k] && m_req[k][0] && (gwait == 0);
        if (pend_q.size() != 0 && dly_q[0] == 0) begin
          m_rsp[k] = {pend_q[0], 1'b1, gnt_v};
        end else begin
          m_rsp[k] = {32'h0, 1'b0, gnt_v};
          if (pend_q.size() != 0) dly_q[0] = dly_q[0] - 1;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (rst[k]) begin
        exp_q.delete();
        pend_q.delete();
        dly_q.delete();
        iss_rd = iss_wr[k];
        gwait = 0;
      end else begin
        if (s_req[k][0] && s_rsp[k][0]) begin
          exp_q.push_back(mem_f(s_req[k][32:1]));
          iss_rd++;
        end
        if (m_req[k][0] && m_rsp[k][0]) begin
          pend_q.push_back(mem_f(m_req[k][32:1]));
          dly_q.push_back(rand_en[k] ? int'($urandom_range(0, 3)) : 0);
          gwait = rand_en[k] ? int'($urandom_range(0, 3)) : 0;
          grants++;
        end else if (m_req[k][0] && gwait > 0) begin
          gwait--;
        end
        if (m_rsp[k][1]) begin
          pend_q.pop_front();
          dly_q.pop_front();
        end
        if (s_rsp[k][1] && (s_req[k][33] || NoRReady)) begin
          rcv++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL r_spurious%0d: actual=%0h required=no beat", k, s_rsp[k][33:2]);
          end else begin
            check($sformatf("r_data%0d", k), s_rsp[k][33:2], exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic push0(input logic [31:0] a);
    iss_mem[0][iss_wr[0]] = a;
    iss_wr[0]++;
  endtask

  task automatic wait_rcv0(input int n, input int budget, input string name);
    int c = 0;
    while (g_port[0].rcv < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, g_port[0].rcv, n);
    repeat (2) @(negedge clk);
  endtask

  task automatic run0();
    int g0;
    int c;
    // back-to-back reads 0x00..0x1C
    for (int i = 0; i < 8; i++) push0(i * 4);
    wait_rcv0(8, 60, "b2b_count");
    check("b2b_idle", idle[0], 1);
    check("b2b_outst", outst0, 0);
    check("mgr_rready_idle", m_req[0][33], 1);

    // credit stall: upstream rready low, 5 requests
    g0 = g_port[0].grants;
    up_rready[0] = 1'b0;
    for (int i = 0; i < 5; i++) push0(32'h100 + i * 4);
    repeat (12) @(negedge clk);
    check("stall_grants", g_port[0].grants - g0, 2);
    check("stall_outst", outst0, 2);
    check("stall_mgr_req", m_req[0][0], 0);
    check("stall_sbr_gnt", s_rsp[0][0], 0);
    check("stall_sbr_rvalid", s_rsp[0][1], 1);
    up_rready[0] = 1'b1;
    wait_rcv0(13, 60, "stall_drain");
    check("stall_idle", idle[0], 1);

    // stalled downstream: no fall-through, stable request
    hold_gnt[0] = 1'b1;
    push0(32'h200);
    push0(32'h204);
    push0(32'h208);
    c = 0;
    while (!(s_req[0][0] && s_rsp[0][0]) && c < 5) begin
      @(negedge clk);
      c++;
    end
    check("a_accept_seen", c < 5, 1);
    check("a_no_fallthrough", m_req[0][0], 0);
    repeat (10) begin
      @(negedge clk);
      check("hold_mgr_req", m_req[0][0], 1);
      check("hold_mgr_a", m_req[0][32:1], 32'h200);
    end
    check("hold_sbr_gnt", s_rsp[0][0], 0);
    hold_gnt[0] = 1'b0;
    wait_rcv0(16, 60, "hold_drain");

    // counter hold: A grant and R pop in the same cycle with one outstanding
    up_rready[0] = 1'b0;
    push0(32'h300);
    repeat (5) @(negedge clk);
    check("cnt_pre_outst", outst0, 1);
    check("cnt_pre_rvalid", s_rsp[0][1], 1);
    hold_gnt[0] = 1'b1;
    push0(32'h304);
    repeat (3) @(negedge clk);
    check("cnt_pre_req", m_req[0][0], 1);
    hold_gnt[0] = 1'b0;
    up_rready[0] = 1'b1;
    @(negedge clk);
    check("cnt_both_hs", (m_req[0][0] && m_rsp[0][0]) && (s_rsp[0][1] && s_req[0][33]), 1);
    check("cnt_same_outst", outst0, 1);
    @(negedge clk);
    check("cnt_hold_outst", outst0, 1);
    wait_rcv0(18, 30, "cnt_drain");
    check("cnt_final_outst", outst0, 0);

    // asynchronous reset with two beats in each FIFO
    up_rready[0] = 1'b0;
    for (int i = 0; i < 4; i++) push0(32'h500 + i * 4);
    repeat (12) @(negedge clk);
    check("rst_pre_rvalid", s_rsp[0][1], 1);
    check("rst_pre_outst", outst0, 2);
    @(posedge clk);
    #3;
    rst[0] = 1'b1;
    #1;
    check("rst_sbr_rvalid", s_rsp[0][1], 0);
    check("rst_mgr_req", m_req[0][0], 0);
    check("rst_outst", outst0, 0);
    check("rst_idle", idle[0], 1);
    check("rst_sbr_gnt", s_rsp[0][0], 0);
    check("rst_mgr_rready", m_req[0][33], 0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    #1;
    check("rst_release_gnt", s_rsp[0][0], 1);
    up_rready[0] = 1'b1;
    push0(32'h40);
    wait_rcv0(19, 30, "post_rst_read");
    check("post_rst_idle", idle[0], 1);
  endtask

  task automatic run1();
    int c = 0;
    for (int i = 0; i < 1000; i++) iss_mem[1][i] = $urandom() & 32'hFFFF_FFFC;
    iss_wr[1] = 1000;
    while (g_port[1].rcv < 1000 && c < 30000) begin
      @(negedge clk);
      c++;
    end
    check("d1_count", g_port[1].rcv, 1000);
    repeat (3) @(negedge clk);
    check("d1_grants", g_port[1].grants, 1000);
    check("d1_idle", idle[1], 1);
    check("d1_outst", outst1, 0);
  endtask

  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    iss_wr[0] = 0;
    iss_wr[1] = 0;
    up_rready[0] = 1'b1;
    up_rready[1] = 1'b0;
    hold_gnt[0] = 1'b0;
    hold_gnt[1] = 1'b0;
    rand_en[0] = 1'b0;
    rand_en[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_sbr_gnt", s_rsp[0][0], 0);
    check("reset_sbr_rvalid", s_rsp[0][1], 0);
    check("reset_mgr_req", m_req[0][0], 0);
    check("reset_mgr_rready", m_req[0][33], 0);
    check("reset_outst", outst0, 0);
    check("reset_idle", idle[0], 1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    check("release_gnt0", s_rsp[0][0], 1);
    check("release_gnt1", s_rsp[1][0], 1);
    fork
      run0();
      run1();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
